// File: rtl/mul_pkg.sv
// Shared types and tiling helpers for the tiled multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: result-window mode encoding, per-stage metadata struct, and
// constant functions that describe how an operand is split into tiles.
package mul_pkg;

  // Result window selected per transaction.
  typedef enum logic [1:0] {
    MODE_FULL   = 2'd0,
    MODE_LOW    = 2'd1,
    MODE_MIDDLE = 2'd2,
    MODE_UPPER2 = 2'd3
  } mode_t;

  // Control carried alongside data through each pipeline stage.
  typedef struct packed {
    logic  vld;
    mode_t mode;
  } meta_t;

  // Number of tiles an operand is cut into; the top tile absorbs the remainder.
  function automatic int num_tiles(input int mul_size, input int tile_width);
    return mul_size / tile_width;
  endfunction

  // First operand bit covered by tile i.
  function automatic int tile_lo(input int i, input int tile_width);
    return i * tile_width;
  endfunction

  // Width of tile i: TILE_W for all but the top tile, remainder for the top one.
  function automatic int tile_w(input int i, input int mul_size, input int tile_width);
    int nt;
    nt = num_tiles(mul_size, tile_width);
    if (i == nt - 1)
      return mul_size - (nt - 1) * tile_width;
    return tile_width;
  endfunction

endpackage

// File: rtl/mul_tile_row.sv
// One row of the tile grid: a_i times every b_j tile, then the shifted row sum.
// Latency: 2 cycles (tile products, then row sum), both gated by en.
// Backpressure: holds all state while en is low; no local flow control.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          global pipeline advance
//   a_tile      operand a bits belonging to tile ROW
//   b           full operand b
//   row_sum     registered sum of a_tile*b_j << (ROW+j)*TILE_W, 2*MUL_SIZE bits
module mul_tile_row
  import mul_pkg::*;
#(
  parameter int MUL_SIZE = 56,
  parameter int TILE_W   = 18,
  parameter int ROW      = 0,
  localparam int AW      = tile_w(ROW, MUL_SIZE, TILE_W),
  localparam int PSW     = 2 * MUL_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [AW-1:0]     a_tile,
  input  logic [MUL_SIZE-1:0] b,
  output logic [PSW-1:0]    row_sum
);

  localparam int NT   = num_tiles(MUL_SIZE, TILE_W);
  // Widest tile is the top one; every product register is sized for it.
  localparam int TMAX = tile_w(NT - 1, MUL_SIZE, TILE_W);
  localparam int PW   = 2 * TMAX;

  logic [TMAX-1:0] b_t  [NT];
  logic [PW-1:0]   prod [NT];
  logic [PSW-1:0]  sum_c;

  for (genvar j = 0; j < NT; j++) begin : g_btile
    localparam int LO = tile_lo(j, TILE_W);
    localparam int W  = tile_w(j, MUL_SIZE, TILE_W);
    assign b_t[j] = TMAX'(b[LO +: W]);
  end

  // Stage 1: unshifted tile products, widened before multiplying so the
  // full w_i+w_j result is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NT; j++) prod[j] <= '0;
    end else if (en) begin
      for (int j = 0; j < NT; j++) prod[j] <= PW'(a_tile) * PW'(b_t[j]);
    end
  end

  // Tile (ROW, j) carries weight 2^((ROW+j)*TILE_W); every shifted product
  // fits inside 2*MUL_SIZE bits, so the row sum cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < NT; j++)
      sum_c = sum_c + (PSW'(prod[j]) << ((ROW + j) * TILE_W));
  end

  // Stage 2: registered row sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  row_sum <= '0;
    else if (en) row_sum <= sum_c;
  end

endmodule

// File: rtl/multiplier_tiled_pipe.sv
// Pipelined unsigned MUL_SIZE x MUL_SIZE multiplier with per-beat result window.
// Latency: 3 cycles from accept to out_valid; each stalled cycle adds one.
// Backpressure: single global enable; in_ready = !out_valid || out_ready, bubbles kept.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand beat handshake
//   in_a, in_b            unsigned operands
//   in_mode               0 FULL, 1 LOW, 2 MIDDLE, 3 UPPER2
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_res               windowed product, zero-extended to 2*MUL_SIZE
//   out_tag               tag of this result
//   out_hi_nz             product bits above 2*RADIX are non-zero
module multiplier_tiled_pipe
  import mul_pkg::*;
#(
  parameter int MUL_SIZE = 56,
  parameter int RADIX    = 54,
  parameter int TILE_W   = 18,
  parameter int TAG_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_SIZE-1:0]   in_a,
  input  logic [MUL_SIZE-1:0]   in_b,
  input  logic [1:0]            in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MUL_SIZE-1:0] out_res,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_hi_nz
);

  localparam int NT  = num_tiles(MUL_SIZE, TILE_W);
  localparam int PSW = 2 * MUL_SIZE;

  logic             en;
  meta_t            s1_meta, s2_meta;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [PSW-1:0]   row_sum [NT];
  logic [PSW-1:0]   p_c;
  logic [PSW-1:0]   res_c;
  logic             hi_nz_c;

  // Everything moves together: the pipe advances whenever the output
  // register is empty or being drained this cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < NT; i++) begin : g_row
    localparam int LO = tile_lo(i, TILE_W);
    localparam int W  = tile_w(i, MUL_SIZE, TILE_W);
    mul_tile_row #(
      .MUL_SIZE (MUL_SIZE),
      .TILE_W   (TILE_W),
      .ROW      (i)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .a_tile  (in_a[LO +: W]),
      .b       (in_b),
      .row_sum (row_sum[i])
    );
  end

  // Metadata for stages 1 and 2, aligned with the row products and row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_meta <= '0;
      s1_tag  <= '0;
      s2_meta <= '0;
      s2_tag  <= '0;
    end else if (en) begin
      s1_meta <= '{vld: in_valid, mode: mode_t'(in_mode)};
      s1_tag  <= in_tag;
      s2_meta <= s1_meta;
      s2_tag  <= s1_tag;
    end
  end

  // Full product from the row sums, then the window select.
  always_comb begin
    p_c = '0;
    for (int i = 0; i < NT; i++) p_c = p_c + row_sum[i];
  end

  always_comb begin
    res_c = '0;
    case (s2_meta.mode)
      MODE_FULL:   res_c = p_c;
      MODE_LOW:    res_c = PSW'(p_c[RADIX-1:0]);
      MODE_MIDDLE: res_c = PSW'(p_c[2*RADIX-1:RADIX]);
      MODE_UPPER2: res_c = PSW'(p_c[2*RADIX+3:2*RADIX+2]);
    endcase
  end

  assign hi_nz_c = |p_c[PSW-1:2*RADIX];

  // Stage 3: output register; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_hi_nz <= 1'b0;
    end else if (en) begin
      out_valid <= s2_meta.vld;
      out_res   <= res_c;
      out_tag   <= s2_tag;
      out_hi_nz <= hi_nz_c;
    end
  end

endmodule

// File: tb/tb_multiplier_tiled_pipe.sv
// Directed bench for multiplier_tiled_pipe with hand-computed expectations.
module tb_multiplier_tiled_pipe;

  localparam int MS  = 56;
  localparam int RX  = 54;
  localparam int TW  = 18;
  localparam int TGW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [MS-1:0]   in_a;
  logic [MS-1:0]   in_b;
  logic [1:0]      in_mode;
  logic [TGW-1:0]  in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*MS-1:0] out_res;
  logic [TGW-1:0]  out_tag;
  logic            out_hi_nz;

  int total = 0;
  int bad   = 0;

  multiplier_tiled_pipe #(
    .MUL_SIZE (MS),
    .RADIX    (RX),
    .TILE_W   (TW),
    .TAG_W    (TGW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_hi_nz (out_hi_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accept, check it stays invisible for two edges, then
  // appears on the third with the expected window, tag and hi flag.
  task automatic run_one(input string name, input logic [MS-1:0] a, input logic [MS-1:0] b,
                         input logic [1:0] mode, input logic [TGW-1:0] tag,
                         input logic [127:0] exp_res, input logic exp_hi);
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_tag   = tag;
    in_valid = 1'b1;
    chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1"}, 128'(out_valid), 128'd0);
    step();
    chk({name, "_lat2"}, 128'(out_valid), 128'd0);
    step();
    chk({name, "_valid"}, 128'(out_valid), 128'd1);
    chk({name, "_res"},   128'(out_res),   exp_res);
    chk({name, "_tag"},   128'(out_tag),   128'(tag));
    chk({name, "_hi_nz"}, 128'(out_hi_nz), 128'(exp_hi));
  endtask

  logic [MS-1:0]  all_ones;
  logic [MS-1:0]  p54;
  logic [MS-1:0]  p55;
  logic [127:0]   exp_sq;
  logic [127:0]   exp_s [4];

  initial begin
    all_ones = '1;
    p54 = '0; p54[54] = 1'b1;
    p55 = '0; p55[55] = 1'b1;
    // (2^56-1)^2 = 2^112 - 2^57 + 1
    exp_sq = (128'd1 << 112) - (128'd1 << 57) + 128'd1;
    exp_s[0] = 128'd200;  // 10*20
    exp_s[1] = 128'd231;  // 11*21
    exp_s[2] = 128'd264;  // 12*22
    exp_s[3] = 128'd299;  // 13*23

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 2'd0;
    in_tag    = '0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_res",   128'(out_res),   128'd0);
    chk("rst_out_tag",   128'(out_tag),   128'd0);
    chk("rst_hi_nz",     128'(out_hi_nz), 128'd0);
    rst_n = 1'b1;
    step();

    // Single-beat windows
    run_one("full_3x5",   56'd3,   56'd5, 2'd0, 4'd1, 128'd15, 1'b0);
    run_one("low_3x5",    56'd3,   56'd5, 2'd1, 4'd2, 128'd15, 1'b0);
    run_one("full_max",   all_ones, all_ones, 2'd0, 4'd3, exp_sq, 1'b1);
    run_one("mid_2p54x3", p54,     56'd3, 2'd2, 4'd4, 128'd3, 1'b0);
    run_one("low_2p54x3", p54,     56'd3, 2'd1, 4'd5, 128'd0, 1'b0);
    run_one("up2_2p55sq", p55,     p55,   2'd3, 4'd6, 128'd1, 1'b1);
    run_one("low_max",    all_ones, all_ones, 2'd1, 4'd7, 128'd1, 1'b1);

    // Back-to-back beats with a 5-cycle consumer stall after the first result
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_a = 56'd10; in_b = 56'd20; in_tag = 4'd0;
    step();
    in_a = 56'd11; in_b = 56'd21; in_tag = 4'd1;
    step();
    in_a = 56'd12; in_b = 56'd22; in_tag = 4'd2;
    step();
    in_a = 56'd13; in_b = 56'd23; in_tag = 4'd3;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready0", 128'(in_ready),  128'd0);
    chk("stall_first_vld", 128'(out_valid), 128'd1);
    chk("stall_first_tag", 128'(out_tag),   128'd0);
    chk("stall_first_res", 128'(out_res),   exp_s[0]);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold_in_ready", 128'(in_ready),  128'd0);
      chk("stall_hold_vld",      128'(out_valid), 128'd1);
      chk("stall_hold_tag",      128'(out_tag),   128'd0);
      chk("stall_hold_res",      128'(out_res),   exp_s[0]);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("drain_vld", 128'(out_valid), 128'd1);
      chk("drain_tag", 128'(out_tag),   128'(k));
      chk("drain_res", 128'(out_res),   exp_s[k]);
      step();
    end
    chk("drain_empty", 128'(out_valid), 128'd0);

    // Reset with three beats in flight
    in_valid = 1'b1;
    in_mode  = 2'd0;
    in_a = 56'd100; in_b = 56'd3; in_tag = 4'd9;
    step();
    in_a = 56'd101; in_tag = 4'd10;
    step();
    in_a = 56'd102; in_tag = 4'd11;
    step();
    in_valid = 1'b0;
    chk("pre_rst_vld", 128'(out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld",      128'(out_valid), 128'd0);
    chk("midrst_res",      128'(out_res),   128'd0);
    chk("midrst_tag",      128'(out_tag),   128'd0);
    chk("midrst_hi_nz",    128'(out_hi_nz), 128'd0);
    chk("midrst_in_ready", 128'(in_ready),  128'd1);
    step();
    step();
    rst_n = 1'b1;
    run_one("post_rst_7x9", 56'd7, 56'd9, 2'd0, 4'd5, 128'd63, 1'b0);
    step();
    chk("post_rst_no_stale", 128'(out_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_tiled_pipe.md
Name: multiplier_tiled_pipe

Overview:
Parametrised, pipelined unsigned MUL_SIZE x MUL_SIZE multiplier built from a square grid of DSP-sized tile products, with a valid/ready stream interface. A per-transaction mode selects the output window: full product, low radix word, middle radix word or upper 2 carry bits. It replaces the fixed-width upper-bit and middle-bit multiplier variants in the Montgomery/Barrett datapath, so one instance serves every radix slice and a downstream stall no longer corrupts results.

Parameters:
MUL_SIZE, 56, operand width in bits; requires MUL_SIZE >= TILE_W.
RADIX, 54, radix word width for window modes; requires RADIX <= MUL_SIZE-2.
TILE_W, 18, tile width. NT = MUL_SIZE/TILE_W (floor). Tiles 0..NT-2 are TILE_W wide; top tile takes the remainder MUL_SIZE-(NT-1)*TILE_W and must be <= 2*TILE_W-1. Defaults give tiles 18/18/20.
TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
in_a  in  MUL_SIZE  operand a, unsigned
in_b  in  MUL_SIZE  operand b, unsigned
in_mode  in  2  0 FULL, 1 LOW, 2 MIDDLE, 3 UPPER2
in_tag  in  TAG_W  opaque tag, returned with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  2*MUL_SIZE  result, zero-extended per mode
out_tag  out  TAG_W  tag of this result
out_hi_nz  out  1  1 when product bits [2*MUL_SIZE-1:2*RADIX] are non-zero

Behaviour:
- Reset: asynchronous, active-low. Clears every stage valid bit, all data/tag/mode registers, out_res, out_tag and out_hi_nz to 0 and out_valid to 0. in_ready is 1 while out_valid is 0. A reset mid-stream discards all in-flight beats; the first beat accepted after rst_n rises completes normally.
- Handshake: global enable en = !out_valid || out_ready; in_ready = en. A beat is accepted when in_valid && in_ready. Outputs stay stable while out_valid && !out_ready. Bubbles travel through the pipe; they are not collapsed. Throughput is 1 beat/cycle when out_ready is held high.
- Pipeline stages, all advancing only when en=1:
  S1: register all NT*NT unshifted tile products a_i*b_j, at width w_i+w_j. Also register valid, mode and tag.
  S2: per row i, sum the tile products shifted by (i+j)*TILE_W into 2*MUL_SIZE bits.
  S3: sum the NT row sums into product P[2*MUL_SIZE-1:0]. Apply the mode window, compute hi_nz and register out_res/out_tag/out_valid.
- Latency: an accepted beat appears on out_valid exactly 3 cycles later if out_ready stays high. Each stalled cycle adds one cycle.
- Window rules: FULL gives P. LOW gives P[RADIX-1:0]. MIDDLE gives P[2*RADIX-1:RADIX]. UPPER2 gives P[2*RADIX+3:2*RADIX+2]. Every mode except FULL is zero-extended to 2*MUL_SIZE bits.
- Arithmetic is exact and unsigned. No truncation occurs anywhere before the window select.
- Simultaneous input accept and output consume in the same cycle is legal and loses no data.
- Ordering: results leave strictly in acceptance order.

Decomposition:
- Shared package mul_pkg:
  mode encoding constants MODE_FULL, MODE_LOW, MODE_MIDDLE, MODE_UPPER2;
  function tile_lo(i) returning a tile's start bit;
  function tile_w(i) returning a tile's width;
  constant function num_tiles(MUL_SIZE, TILE_W).
- One sub-module: mul_tile_row. It computes one row: the NT registered tile products for a_i, the shifted row sum and the enable-gated registers. It is instantiated NT times by generate.

Test Plan:
- a=3, b=5, mode FULL, tag 1 -> out_res=15, tag 1, hi_nz=0, exactly 3 cycles after accept.
- a=b=2^56-1, FULL -> out_res=2^112-2^57+1, hi_nz=1.
- a=2^54, b=3, MIDDLE -> out_res=3. The same operands with LOW -> out_res=0.
- a=b=2^55, UPPER2 -> P=2^110, out_res=1 (bits 111:110 = 01).
- 4 back-to-back beats with tags 0-3, out_ready low for 5 cycles after the first result -> in_ready drops, out_* held stable, then tags 0-3 emerge in order with correct products and no loss.
- Assert rst_n low with 3 beats in flight -> all outputs 0 immediately. After release, a beat a=7, b=9 yields 63 in 3 cycles with no stale results.
